// File: rtl/cam_pkg.sv
// Shared types for the MAC learning CAM: FSM states and the stored entry.
// Entry fields are sized for the widest supported build; narrower builds zero-extend.
package cam_pkg;

  localparam int KEY_W_MAX  = 64;
  localparam int PORT_W_MAX = 8;
  localparam int AGE_W_MAX  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FLUSH
  } cam_state_t;

  typedef struct packed {
    logic                  valid;
    logic [KEY_W_MAX-1:0]  key;
    logic [PORT_W_MAX-1:0] port;
    logic [AGE_W_MAX-1:0]  age;
  } cam_entry_t;

endpackage

// File: rtl/cam_priority_encoder.sv
// Lowest-set-bit encoder: returns index of the first set bit and an any flag.
module cam_priority_encoder #(
  parameter int WIDTH = 32,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/mac_learning_cam.sv
// MAC learning table: learn/lookup/delete with refresh, background aging
// sweep, whole-table flush and occupancy status.
module mac_learning_cam
  import cam_pkg::*;
#(
  parameter int KEY_WIDTH       = 48,
  parameter int TABLE_DEPTH     = 32,
  parameter int PORT_COUNT      = 8,
  parameter int AGE_WIDTH       = 3,
  parameter int AGE_TICK_CYCLES = 1000000,
  localparam int PW = $clog2(PORT_COUNT),
  localparam int CW = $clog2(TABLE_DEPTH + 1)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_learn_valid,
  input  logic [KEY_WIDTH-1:0] i_learn_key,
  input  logic [PW-1:0]        i_learn_port,
  output logic                 o_learn_ready,
  input  logic                 i_lookup_valid,
  input  logic [KEY_WIDTH-1:0] i_lookup_key,
  output logic                 o_result_valid,
  output logic                 o_result_hit,
  output logic [PW-1:0]        o_result_port,
  input  logic                 i_delete_valid,
  input  logic [KEY_WIDTH-1:0] i_delete_key,
  input  logic                 i_flush,
  output logic [CW-1:0]        o_entry_count,
  output logic                 o_table_full,
  output logic                 o_learn_dropped,
  output logic                 o_aged_out
);

  localparam int IW = $clog2(TABLE_DEPTH);
  localparam int TW = $clog2(AGE_TICK_CYCLES);
  localparam int AGE_MAX = (1 << AGE_WIDTH) - 1;

  cam_entry_t r_tab [TABLE_DEPTH];
  cam_entry_t w_tab [TABLE_DEPTH];

  cam_state_t    r_state;
  logic [IW-1:0] r_sweep_idx;
  logic [TW-1:0] r_tick;
  logic          r_pending;
  logic          r_learn_ready;
  logic          r_res_valid;
  logic          r_res_hit;
  logic [PW-1:0] r_res_port;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_dropped;
  logic          r_aged;

  logic [TABLE_DEPTH-1:0] w_free_vec;
  logic [TABLE_DEPTH-1:0] w_lm_vec;
  logic [TABLE_DEPTH-1:0] w_km_vec;
  logic [TABLE_DEPTH-1:0] w_dm_vec;
  logic [IW-1:0]          w_free_idx;
  logic [IW-1:0]          w_lm_idx;
  logic [IW-1:0]          w_km_idx;
  logic [IW-1:0]          w_dm_idx;
  logic                   w_free_any;
  logic                   w_lm_any;
  logic                   w_km_any;
  logic                   w_dm_any;

  logic          w_same;
  logic          w_learn_go;
  logic          w_learn_hit;
  logic          w_ins;
  logic          w_drop;
  logic          w_del;
  logic          w_look_hit;
  logic          w_sweep;
  logic          w_aged;
  logic          w_wrap;
  logic          w_refresh;
  logic [CW-1:0] w_count_nxt;

  always_comb begin
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      w_free_vec[i] = !r_tab[i].valid;
      w_lm_vec[i] = r_tab[i].valid &&
        (r_tab[i].key == KEY_W_MAX'(i_learn_key));
      w_km_vec[i] = r_tab[i].valid &&
        (r_tab[i].key == KEY_W_MAX'(i_lookup_key));
      w_dm_vec[i] = r_tab[i].valid &&
        (r_tab[i].key == KEY_W_MAX'(i_delete_key));
    end
  end

  cam_priority_encoder #(.WIDTH(TABLE_DEPTH)) u_free (
    .i_vec (w_free_vec),
    .o_idx (w_free_idx),
    .o_any (w_free_any)
  );

  cam_priority_encoder #(.WIDTH(TABLE_DEPTH)) u_learn (
    .i_vec (w_lm_vec),
    .o_idx (w_lm_idx),
    .o_any (w_lm_any)
  );

  cam_priority_encoder #(.WIDTH(TABLE_DEPTH)) u_lookup (
    .i_vec (w_km_vec),
    .o_idx (w_km_idx),
    .o_any (w_km_any)
  );

  cam_priority_encoder #(.WIDTH(TABLE_DEPTH)) u_delete (
    .i_vec (w_dm_vec),
    .o_idx (w_dm_idx),
    .o_any (w_dm_any)
  );

  // A delete of the learn key in the same cycle cancels the learn outright
  assign w_same = i_delete_valid && i_learn_valid &&
                  (i_delete_key == i_learn_key);
  assign w_learn_go  = i_learn_valid && r_learn_ready &&
                       !w_same && !i_flush;
  assign w_learn_hit = w_learn_go && w_lm_any;
  assign w_ins  = w_learn_go && !w_lm_any && w_free_any;
  assign w_drop = w_learn_go && !w_lm_any && !w_free_any;
  assign w_del  = i_delete_valid && w_dm_any && !i_flush;
  assign w_look_hit = i_lookup_valid && w_km_any;
  assign w_sweep = (r_state == SWEEP) && !i_flush;
  assign w_wrap  = (r_tick == TW'(AGE_TICK_CYCLES - 1));

  // Later writes override earlier ones, encoding per-entry priority
  always_comb begin
    w_aged = 1'b0;
    w_refresh = 1'b0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      w_tab[i] = r_tab[i];
      if (w_sweep && (i == int'(r_sweep_idx)) && r_tab[i].valid &&
          !(w_del && (i == int'(w_dm_idx)))) begin
        w_refresh = (w_learn_hit && (i == int'(w_lm_idx))) ||
                    (w_look_hit && (i == int'(w_km_idx)));
        if (!w_refresh) begin
          if (r_tab[i].age == AGE_W_MAX'(AGE_MAX)) begin
            w_tab[i].valid = 1'b0;
            w_aged = 1'b1;
          end else begin
            w_tab[i].age = r_tab[i].age + AGE_W_MAX'(1);
          end
        end
      end
      if (w_look_hit && (i == int'(w_km_idx))) w_tab[i].age = '0;
      if (w_learn_hit && (i == int'(w_lm_idx))) begin
        w_tab[i].port = PORT_W_MAX'(i_learn_port);
        w_tab[i].age  = '0;
      end
      if (w_ins && (i == int'(w_free_idx))) begin
        w_tab[i].valid = 1'b1;
        w_tab[i].key   = KEY_W_MAX'(i_learn_key);
        w_tab[i].port  = PORT_W_MAX'(i_learn_port);
        w_tab[i].age   = '0;
      end
      if (w_del && (i == int'(w_dm_idx))) w_tab[i].valid = 1'b0;
      if (i_flush) w_tab[i].valid = 1'b0;
    end
  end

  always_comb begin
    w_count_nxt = r_count + CW'(w_ins) - CW'(w_del) - CW'(w_aged);
    if (i_flush) w_count_nxt = '0;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < TABLE_DEPTH; i++) r_tab[i] <= '0;
      r_state       <= IDLE;
      r_sweep_idx   <= '0;
      r_tick        <= '0;
      r_pending     <= 1'b0;
      r_learn_ready <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_hit     <= 1'b0;
      r_res_port    <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_dropped     <= 1'b0;
      r_aged        <= 1'b0;
    end else begin
      r_tab         <= w_tab;
      r_learn_ready <= !i_flush;
      r_res_valid   <= i_lookup_valid;
      r_res_hit     <= w_look_hit;
      r_res_port    <= w_look_hit ? PW'(r_tab[w_km_idx].port) : '0;
      r_count       <= w_count_nxt;
      r_full        <= (w_count_nxt == CW'(TABLE_DEPTH));
      r_dropped     <= w_drop;
      r_aged        <= w_aged;
      r_tick        <= w_wrap ? '0 : r_tick + TW'(1);
      if (i_flush) begin
        r_state     <= FLUSH;
        r_tick      <= '0;
        r_pending   <= 1'b0;
        r_sweep_idx <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_wrap || r_pending) begin
              r_state     <= SWEEP;
              r_sweep_idx <= '0;
              r_pending   <= 1'b0;
            end
          end
          SWEEP: begin
            if (w_wrap) r_pending <= 1'b1;
            if (r_sweep_idx == IW'(TABLE_DEPTH - 1)) begin
              r_state <= IDLE;
            end else begin
              r_sweep_idx <= r_sweep_idx + IW'(1);
            end
          end
          FLUSH: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_learn_ready   = r_learn_ready;
  assign o_result_valid  = r_res_valid;
  assign o_result_hit    = r_res_hit;
  assign o_result_port   = r_res_port;
  assign o_entry_count   = r_count;
  assign o_table_full    = r_full;
  assign o_learn_dropped = r_dropped;
  assign o_aged_out      = r_aged;

endmodule
